// File: rtl/ssd_scan_ctrl.sv
// Multi-digit seven-segment scan controller. It provides per-digit enable, decimal point,
// leading-zero blanking, slot dead-time and a frame-aligned double buffer.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE     = 262144,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic                    pending,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [7:0]              cathodes
);
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, disp_en_q, disp_en_d;
  logic                    pending_q, pending_d, frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
  logic [7:0]              cathodes_q, cathodes_d;
  logic [NUM_DIGITS-1:0]   sup;
  logic                    boundary;
  logic [3:0]              nib;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'b0000001;  4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;  4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;  4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;  4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;  4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;  default: seg7 = 7'b0111000;
    endcase
  endfunction

  // Leading-zero blanking walks enabled digits from the top; disabled digits are skipped.
  always_comb begin
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] lower_mask;
    sup      = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lower_mask = (NUM_DIGITS'(1) << i) - NUM_DIGITS'(1);
      if (disp_en_q[i]) begin
        if (lz_suppress && zero_run && (disp_dig_q[4*i +: 4] == 4'h0) &&
            |(disp_en_q & lower_mask))
          sup[i] = 1'b1;
        if (disp_dig_q[4*i +: 4] != 4'h0)
          zero_run = 1'b0;
      end
    end
  end

  always_comb begin
    boundary = (idx_q == IDX_MAX) && (cnt_q == CNT_MAX);
    cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (cnt_q == CNT_MAX)
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    // State register tracks the counter value it is paired with.
    state_d  = (cnt_d < BLANK_END) ? ST_BLANK : ST_DRIVE;

    pend_dig_d = load ? digits_in : pend_dig_q;
    pend_dp_d  = load ? dp_in     : pend_dp_q;
    pend_en_d  = load ? digit_en  : pend_en_q;
    pending_d  = boundary ? 1'b0 : (load | pending_q);
    disp_dig_d = disp_dig_q;
    disp_dp_d  = disp_dp_q;
    disp_en_d  = disp_en_q;
    if (boundary) begin
      if (load) begin
        disp_dig_d = digits_in;
        disp_dp_d  = dp_in;
        disp_en_d  = digit_en;
      end else if (pending_q) begin
        disp_dig_d = pend_dig_q;
        disp_dp_d  = pend_dp_q;
        disp_en_d  = pend_en_q;
      end
    end
    frame_done_d = boundary;

    nib        = disp_dig_q[4*int'(idx_q) +: 4];
    anodes_d   = '1;
    cathodes_d = 8'hFF;
    if (state_q == ST_DRIVE && disp_en_q[idx_q]) begin
      if (!sup[idx_q]) begin
        anodes_d[idx_q] = 1'b0;
        cathodes_d      = {seg7(nib), ~disp_dp_q[idx_q]};
      end else if (disp_dp_q[idx_q]) begin
        anodes_d[idx_q] = 1'b0;
        cathodes_d      = 8'b1111_1110;
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      disp_dig_q   <= '0;
      disp_dp_q    <= '0;
      // Enables come up all-on so an unloaded display scans zeros on every digit.
      disp_en_q    <= '1;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      anodes_q     <= '1;
      cathodes_q   <= 8'hFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      disp_dig_q   <= disp_dig_d;
      disp_dp_q    <= disp_dp_d;
      disp_en_q    <= disp_en_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      anodes_q     <= anodes_d;
      cathodes_q   <= cathodes_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_done_q;
  assign anodes     = anodes_q;
  assign cathodes   = cathodes_q;
endmodule
